// File: rtl/hs_alu_seq_if.sv
// hs_alu_seq request/result bundle between control unit and ALU.
// Optional zf/nf flag lines exist only when ALU_FLAGS_EN is defined.
interface hs_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic               Req;
  logic [1:0]         Cmd;
  logic               cin;
  logic [WIDTH-1:0]   Op1;
  logic [WIDTH-1:0]   Op2;
  logic [2*WIDTH-1:0] Alu_Out;
  logic               cout;
  logic               dz;
  logic               busy;
  logic               Ack;
`ifdef ALU_FLAGS_EN
  logic               zf;
  logic               nf;

  modport master (
    output Req, Cmd, cin, Op1, Op2,
    input  Alu_Out, cout, dz, busy, Ack,
    input  zf, nf
  );

  modport slave (
    input  Req, Cmd, cin, Op1, Op2,
    output Alu_Out, cout, dz, busy, Ack,
    output zf, nf
  );
`else
  modport master (
    output Req, Cmd, cin, Op1, Op2,
    input  Alu_Out, cout, dz, busy, Ack
  );

  modport slave (
    input  Req, Cmd, cin, Op1, Op2,
    output Alu_Out, cout, dz, busy, Ack
  );
`endif
endinterface

// File: rtl/hs_alu_seq.sv
// Req/Ack ALU: single-cycle add/sub, shift-add mul, restoring div.
// Define ALU_FLAGS_EN to add zero/negative flag outputs zf and nf.
module hs_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic         clk,
  input logic         rst_n,
  hs_alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               req_q;
  logic               div_q, div_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               cout_q, cout_d;
  logic               dz_q, dz_d;

  logic               start;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_sh;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_df;
  logic               div_ok;
  logic [WIDTH:0]     div_qs;
  logic [2*WIDTH-1:0] div_nx;
  logic [2*WIDTH-1:0] step_nx;

  assign start = bus.Req & ~req_q & (state_q == IDLE);

  assign add_s = {1'b0, bus.Op1}
               + {1'b0, bus.Op2}
               + {{WIDTH{1'b0}}, bus.cin};
  assign sub_s = {1'b0, bus.Op1}
               - {1'b0, bus.Op2}
               - {{WIDTH{1'b0}}, bus.cin};

  // mul: p_q = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
                 + (p_q[0] ? {1'b0, b_q} : '0);
  assign mul_sh  = {mul_sum, p_q[WIDTH-1:0]};
  assign mul_nx  = mul_sh[2*WIDTH:1];

  // div: p_q = {partial remainder, dividend/quotient shift reg}
  assign div_sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign div_df = div_sh - {1'b0, b_q};
  assign div_ok = ~div_df[WIDTH];
  assign div_qs = {p_q[WIDTH-1:0], div_ok};
  assign div_nx = {div_ok ? div_df[WIDTH-1:0]
                          : div_sh[WIDTH-1:0],
                   div_qs[WIDTH-1:0]};

  assign step_nx = div_q ? div_nx : mul_nx;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    p_d     = p_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    cout_d  = cout_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          b_d   = bus.Op2;
          cnt_d = '0;
          p_d   = {{WIDTH{1'b0}}, bus.Op1};
          unique case (bus.Cmd)
            2'b00: begin
              out_d   = {{WIDTH{1'b0}}, add_s[WIDTH-1:0]};
              cout_d  = add_s[WIDTH];
              dz_d    = 1'b0;
              state_d = DONE;
            end
            2'b01: begin
              out_d   = {{WIDTH{1'b0}}, sub_s[WIDTH-1:0]};
              cout_d  = sub_s[WIDTH];
              dz_d    = 1'b0;
              state_d = DONE;
            end
            2'b10: begin
              div_d   = 1'b0;
              state_d = CALC;
            end
            2'b11: begin
              div_d   = 1'b1;
              state_d = CALC;
            end
          endcase
        end
      end
      CALC: begin
        p_d   = step_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          out_d   = step_nx;
          cout_d  = 1'b0;
          dz_d    = div_q & (b_q == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      div_q   <= 1'b0;
      p_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= bus.Req;
      div_q   <= div_d;
      p_q     <= p_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      cout_q  <= cout_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.Alu_Out = out_q;
  assign bus.cout    = cout_q;
  assign bus.dz      = dz_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.Ack     = (state_q == DONE);

`ifdef ALU_FLAGS_EN
  logic zf_q;
  logic nf_q;
  logic upd;

  // entering DONE from IDLE means add/sub, from CALC means mul/div
  assign upd = (state_d == DONE) && (state_q != DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      nf_q <= 1'b0;
    end else if (upd) begin
      zf_q <= (out_d == '0);
      nf_q <= (state_q == IDLE) ? out_d[WIDTH-1]
                                : out_d[2*WIDTH-1];
    end
  end

  assign bus.zf = zf_q;
  assign bus.nf = nf_q;
`endif

endmodule

// File: tb/tb_hs_alu_seq.sv
// Self-checking bench for hs_alu_seq: vector table, random ops
// against an arithmetic model, and handshake/reset corner cases.
module tb_hs_alu_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hs_alu_seq_if #(.WIDTH(W)) bus();

  hs_alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  int          ack_n, ack_k1, ack_k2;
  int          busy_n, busy_lo, busy_hi;
  logic [15:0] r_out, r_out2;
  logic        r_cout, r_dz;
  logic        r_zf, r_nf;

  typedef struct {
    logic [1:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic [15:0] o;
    logic        co;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void model(
    input  logic [1:0]  cmd,
    input  int          a,
    input  int          b,
    input  int          c,
    output logic [15:0] o,
    output logic        co,
    output logic        dz,
    output int          lat
  );
    int s;
    co  = 1'b0;
    dz  = 1'b0;
    lat = W + 1;
    case (cmd)
      2'd0: begin
        s   = a + b + c;
        o   = 16'(s % 256);
        co  = (s >= 256);
        lat = 1;
      end
      2'd1: begin
        s   = a - b - c;
        o   = 16'((s + 512) % 256);
        co  = (s < 0);
        lat = 1;
      end
      2'd2: o = 16'(a * b);
      default: begin
        if (b == 0) begin
          o  = {8'(a), 8'hFF};
          dz = 1'b1;
        end else begin
          o = {8'(a % b), 8'(a / b)};
        end
      end
    endcase
  endfunction

  task automatic run(input logic [1:0] cmd,
                     input logic [7:0] a,
                     input logic [7:0] b,
                     input logic       c,
                     input bit         hold,
                     input int         p_on,
                     input int         p_off,
                     input int         ncyc,
                     input bit         scram);
    ack_n = 0; ack_k1 = 0; ack_k2 = 0;
    busy_n = 0; busy_lo = 0; busy_hi = 0;
    @(negedge clk);
    bus.Cmd = cmd;
    bus.Op1 = a;
    bus.Op2 = b;
    bus.cin = c;
    bus.Req = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        busy_n++;
        if (busy_lo == 0) busy_lo = k;
        busy_hi = k;
      end
      if (bus.Ack) begin
        ack_n++;
        if (ack_n == 1) begin
          ack_k1 = k;
          r_out  = bus.Alu_Out;
          r_cout = bus.cout;
          r_dz   = bus.dz;
`ifdef ALU_FLAGS_EN
          r_zf   = bus.zf;
          r_nf   = bus.nf;
`endif
        end else begin
          ack_k2 = k;
          r_out2 = bus.Alu_Out;
        end
      end
      bus.Req = hold || (k >= p_on && k < p_off);
      if (scram) begin
        bus.Op1 = 8'($urandom);
        bus.Op2 = 8'($urandom);
        bus.cin = 1'($urandom);
        bus.Cmd = 2'($urandom);
      end
    end
    bus.Req = 1'b0;
  endtask

  task automatic check_op(input string       nm,
                          input logic [1:0]  cmd,
                          input logic [15:0] o,
                          input logic        co,
                          input logic        dz,
                          input int          lat);
    chk({nm, " lat"},    ack_k1,  lat);
    chk({nm, " acks"},   ack_n,   1);
    chk({nm, " out"},    r_out,   o);
    chk({nm, " cout"},   r_cout,  co);
    chk({nm, " dz"},     r_dz,    dz);
    chk({nm, " busy_n"}, busy_n,  lat);
    chk({nm, " busy_lo"}, busy_lo, 1);
    chk({nm, " busy_hi"}, busy_hi, lat);
`ifdef ALU_FLAGS_EN
    chk({nm, " zf"}, r_zf, o == 16'h0);
    chk({nm, " nf"}, r_nf, cmd[1] ? o[15] : o[7]);
`endif
  endtask

  task automatic check_idle_outs(input string nm);
    chk({nm, " out"},  bus.Alu_Out, 0);
    chk({nm, " cout"}, bus.cout, 0);
    chk({nm, " dz"},   bus.dz, 0);
    chk({nm, " busy"}, bus.busy, 0);
    chk({nm, " ack"},  bus.Ack, 0);
`ifdef ALU_FLAGS_EN
    chk({nm, " zf"}, bus.zf, 0);
    chk({nm, " nf"}, bus.nf, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] eo;
    logic        eco, edz;
    int          elat;
    logic [1:0]  rc;
    logic [7:0]  ra, rb;
    logic        rcin;
    int          ack_seen;

    tbl[0]  = '{2'd0, 8'hFF, 8'h01, 1'b1, 16'h0001, 1'b1, 1'b0, 1};
    tbl[1]  = '{2'd1, 8'h05, 8'h07, 1'b0, 16'h00FE, 1'b1, 1'b0, 1};
    tbl[2]  = '{2'd2, 8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0, 1'b0, 9};
    tbl[3]  = '{2'd3, 8'd100, 8'd7, 1'b0, 16'h020E, 1'b0, 1'b0, 9};
    tbl[4]  = '{2'd3, 8'h23, 8'h00, 1'b0, 16'h23FF, 1'b0, 1'b1, 9};
    tbl[5]  = '{2'd0, 8'h00, 8'h00, 1'b0, 16'h0000, 1'b0, 1'b0, 1};
    tbl[6]  = '{2'd1, 8'h00, 8'h00, 1'b1, 16'h00FF, 1'b1, 1'b0, 1};
    tbl[7]  = '{2'd1, 8'h80, 8'h7F, 1'b1, 16'h0000, 1'b0, 1'b0, 1};
    tbl[8]  = '{2'd2, 8'h00, 8'hFF, 1'b1, 16'h0000, 1'b0, 1'b0, 9};
    tbl[9]  = '{2'd3, 8'hFF, 8'h01, 1'b1, 16'h00FF, 1'b0, 1'b0, 9};
    tbl[10] = '{2'd3, 8'h07, 8'h09, 1'b0, 16'h0700, 1'b0, 1'b0, 9};

    bus.Req = 1'b0;
    bus.Cmd = 2'd0;
    bus.cin = 1'b0;
    bus.Op1 = '0;
    bus.Op2 = '0;

    #12;
    check_idle_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run(tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].c,
          1'b0, 0, 0, tbl[i].lat + 2, 1'b0);
      check_op($sformatf("vec%0d", i), tbl[i].cmd,
               tbl[i].o, tbl[i].co, tbl[i].dz, tbl[i].lat);
    end

    for (int n = 0; n < 60; n++) begin
      rc   = 2'($urandom);
      ra   = 8'($urandom);
      rb   = (n % 10 == 0) ? 8'h00 : 8'($urandom);
      rcin = 1'($urandom);
      model(rc, int'(ra), int'(rb), int'(rcin), eo, eco, edz, elat);
      run(rc, ra, rb, rcin, 1'b0, 0, 0, elat + 2, 1'b0);
      check_op($sformatf("rnd%0d", n), rc, eo, eco, edz, elat);
    end

    // Req held high through DONE, operands scrambled after cycle 0
    run(2'd2, 8'h0D, 8'h0B, 1'b0, 1'b1, 0, 0, 14, 1'b1);
    check_op("hold", 2'd2, 16'h008F, 1'b0, 1'b0, 9);

    // extra Req pulse at cycle 4 while busy
    run(2'd3, 8'hC8, 8'h0D, 1'b0, 1'b0, 4, 5, 14, 1'b1);
    check_op("pulse", 2'd3, 16'h050F, 1'b0, 1'b0, 9);

    // Req rises in the DONE cycle and stays high: ignored
    run(2'd2, 8'h03, 8'h05, 1'b0, 1'b0, 9, 11, 22, 1'b0);
    check_op("done_rise", 2'd2, 16'h000F, 1'b0, 1'b0, 9);

    // Req rises in the first IDLE cycle: second op accepted
    run(2'd2, 8'h03, 8'h05, 1'b0, 1'b0, 10, 11, 22, 1'b0);
    chk("idle_rise acks", ack_n, 2);
    chk("idle_rise k1", ack_k1, 9);
    chk("idle_rise k2", ack_k2, 19);
    chk("idle_rise out2", r_out2, 16'h000F);
    chk("idle_rise busy_n", busy_n, 18);

    run(2'd0, 8'h10, 8'h20, 1'b1, 1'b0, 2, 3, 6, 1'b0);
    chk("add_b2b acks", ack_n, 2);
    chk("add_b2b k2", ack_k2, 3);
    chk("add_b2b out2", r_out2, 16'h0031);

    // reset in the middle of a multiply
    ack_seen = 0;
    @(negedge clk);
    bus.Cmd = 2'd2;
    bus.Op1 = 8'hC3;
    bus.Op2 = 8'h5A;
    bus.Req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.Ack) ack_seen++;
      bus.Req = 1'b0;
    end
    @(negedge clk);
    chk("mid busy", bus.busy, 1);
    chk("mid prev out", bus.Alu_Out, 16'h0031);
    rst_n = 1'b0;
    #1;
    check_idle_outs("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.Ack || bus.busy) ack_seen++;
    end
    chk("mid no ack", ack_seen, 0);
    run(2'd2, 8'hC3, 8'h5A, 1'b0, 1'b0, 0, 0, 11, 1'b0);
    check_op("post_rst", 2'd2, 16'h448E, 1'b0, 1'b0, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_alu_seq.md
Name: hs_alu_seq

Overview:
- Parametrised successor of the team's 8-bit request/acknowledge ALU.
- Operand width is generic. Multiply is a sequential shift-add; divide is a sequential restoring divider that returns both quotient and remainder.
- Adds a true clocked reset, a busy indication and a divide-by-zero flag.
- Sits between the miniComputer control unit (request side) and the register file (result side).

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Req  in  1  start request; only the rising edge is used.
- Cmd  in  2  operation: 00 add, 01 sub, 10 mul, 11 div.
- cin  in  1  carry-in (add) / borrow-in (sub); ignored for mul and div.
- Op1  in  WIDTH  operand A / dividend.
- Op2  in  WIDTH  operand B / divisor.
- Alu_Out  out  2*WIDTH  result; held until the next completion.
- cout  out  1  carry (add) / borrow (sub); 0 for mul and div.
- dz  out  1  divide-by-zero flag for the last div.
- busy  out  1  high while an operation is in progress.
- Ack  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0): all outputs 0 (Alu_Out, cout, dz, busy, Ack); state IDLE; counter 0; Req edge detector register = 0.
- Start condition: Req=1 while req_q=0 and state=IDLE. This cycle is "cycle 0".
  - Op1, Op2, cin and Cmd are latched at cycle 0.
  - Inputs may change after cycle 0 without effect.
- Req ignore rules:
  - Rising edge while busy: ignored and not queued.
  - Req held high: no retrigger. It must fall and rise again to start a new operation.
- States: IDLE -> CALC -> DONE -> IDLE.
  - IDLE: busy=0.
  - CALC: busy=1.
  - DONE: busy=1 for exactly one cycle. Ack=1 in this cycle, and Alu_Out/cout/dz update on the same edge that raises Ack.
- Add (00): no CALC cycles; DONE at cycle 1.
  - Alu_Out = {WIDTH zeros, sum[WIDTH-1:0]}, where sum = Op1+Op2+cin.
  - cout = carry out of bit WIDTH-1.
- Sub (01): no CALC cycles; DONE at cycle 1.
  - Alu_Out = {WIDTH zeros, (Op1-Op2-cin) mod 2^WIDTH}.
  - cout = 1 if Op1 < Op2+cin (borrow).
- Mul (10): WIDTH CALC cycles (one shift-add per cycle); DONE at cycle WIDTH+1.
  - Alu_Out = full unsigned 2*WIDTH product; cout = 0.
- Div (11): WIDTH CALC cycles (one restoring step per cycle); DONE at cycle WIDTH+1.
  - Alu_Out = {remainder, quotient}, unsigned; cout = 0.
  - Op2=0: latency unchanged; quotient = all ones, remainder = Op1, dz=1.
  - dz=0 for every other completed operation.
- Output hold: Ack low outside DONE; Alu_Out/cout/dz hold their value between completions.
- Reset mid-operation: abort immediately, no Ack, outputs return to reset values.
- Boundaries:
  - WIDTH=1 must work (mul/div take 1 CALC cycle).
  - Req rising in the DONE cycle: ignored.
  - Req rising in the first IDLE cycle after DONE: accepted, provided req_q=0.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: extra output ports zf (1) and nf (1), updated together with Alu_Out at DONE.
  - zf = (Alu_Out == 0).
  - nf = bit WIDTH-1 of Alu_Out for add/sub, bit 2*WIDTH-1 for mul/div.
  - Both reset to 0.
- Not defined: ports and logic absent; all other behaviour identical.

Test Plan:
- WIDTH=8, add Op1=8'hFF, Op2=8'h01, cin=1 -> Ack at cycle 1, Alu_Out=16'h0001, cout=1, busy high at cycles 1 only.
- Sub Op1=8'h05, Op2=8'h07, cin=0 -> Ack at cycle 1, Alu_Out=16'h00FE, cout=1.
- Mul Op1=8'hFF, Op2=8'hFF -> busy cycles 1-9, Ack at cycle 9, Alu_Out=16'hFE01, cout=0.
- Div 100/7 -> Ack at cycle 9, Alu_Out=16'h020E, dz=0; div 8'h23/0 -> Alu_Out=16'h23FF, dz=1.
- Mul with Req held high through DONE, plus an extra Req pulse at cycle 4 -> exactly one Ack; Op1/Op2 changes after cycle 0 do not alter the result.
- rst_n low at cycle 5 of a mul -> all outputs 0 immediately, no Ack; next Req edge after reset completes normally.
